branch_predictor_unit: RTL and testbench

BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_btb.sv | 60 ++++++
 rtl/branch_predictor_unit.sv | 207 ++++++++++++++++++++
 tb/tb_branch_predictor_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: FSM state encoding,
// indexing-mode selectors and saturating counter arithmetic.
package bp_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_t;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;

   // Widest counter the helpers handle; callers narrow the result to CTR_W.
   localparam int CTR_MAX_W = 4;

   // Increment, holding at the all-ones value of a ctr_w-bit counter.
   function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] ctr,
                                                    input int ctr_w);
      logic [CTR_MAX_W-1:0] max_val;
      max_val = CTR_MAX_W'((1 << ctr_w) - 1);
      return (ctr >= max_val) ? ctr : ctr + CTR_MAX_W'(1);
   endfunction

   // Decrement, holding at zero.
   function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] ctr,
                                                    input int ctr_w);
      logic [CTR_MAX_W-1:0] unused_w;
      unused_w = CTR_MAX_W'(ctr_w);
      return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer: direct-mapped valid/tag/target arrays with a
// combinational lookup port and a single synchronous write port.
module bp_btb #(
   parameter int BTB_IDX_W = 6,
   parameter int TAG_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lookup_pc,
   output logic        hit,
   output logic [31:0] target,
   input  logic        wr_en,
   input  logic [31:0] wr_pc,
   input  logic [31:0] wr_target
);

   localparam int BTB_DEPTH = 1 << BTB_IDX_W;

   logic [BTB_DEPTH-1:0] valid_reg;
   logic [TAG_W-1:0]     tag_mem    [BTB_DEPTH];
   logic [31:0]          target_mem [BTB_DEPTH];

   logic [BTB_IDX_W-1:0] rd_idx;
   logic [TAG_W-1:0]     rd_tag;
   logic [BTB_IDX_W-1:0] wr_idx;
   logic [TAG_W-1:0]     wr_tag;
   logic                 unused_pc_bits;

   assign rd_idx = lookup_pc[BTB_IDX_W+1:2];
   assign rd_tag = lookup_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];
   assign wr_idx = wr_pc[BTB_IDX_W+1:2];
   assign wr_tag = wr_pc[BTB_IDX_W+TAG_W+1:BTB_IDX_W+2];

   // Only the index and tag fields of the PCs take part in the lookup.
   assign unused_pc_bits = ^{lookup_pc, wr_pc};

   // Lookup reads the pre-write contents; a miss drives a zero target.
   always_comb begin
      hit    = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
      target = hit ? target_mem[rd_idx] : 32'd0;
   end

   // Valid bits are the only BTB state that needs clearing on reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_reg <= '0;
      end else if (wr_en) begin
         valid_reg[wr_idx] <= 1'b1;
      end
   end

   // Tag and target storage, meaningful only once the valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]    <= wr_tag;
         target_mem[wr_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/branch_predictor_unit.sv
// Branch predictor: bimodal or gshare pattern-history table of saturating
// counters, speculative global history with EX-stage repair, a BTB for
// targets, a power-up sweep that initialises the PHT and a mispredict count.
module branch_predictor_unit
   import bp_pkg::*;
#(
   parameter int PHT_IDX_W = 10,
   parameter int GHR_W     = 10,
   parameter int BTB_IDX_W = 6,
   parameter int TAG_W     = 8,
   parameter int CTR_W     = 2,
   parameter int MODE      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lookup_en_F,
   input  logic [31:0]          PC_F,
   input  logic                 stall_F,
   output logic                 pred_taken_F,
   output logic [31:0]          pred_target_F,
   output logic                 btb_hit_F,
   output logic [PHT_IDX_W-1:0] pred_index_F,
   output logic [GHR_W-1:0]     ghr_ckpt_F,
   input  logic                 update_en_EX,
   input  logic [31:0]          PC_EX,
   input  logic [PHT_IDX_W-1:0] index_EX,
   input  logic [GHR_W-1:0]     ghr_EX,
   input  logic                 taken_EX,
   input  logic [31:0]          target_EX,
   input  logic                 mispredict_EX,
   output logic                 init_busy,
   output logic [31:0]          mispredict_cnt
);

   localparam int PHT_DEPTH = 1 << PHT_IDX_W;
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

   bp_state_t              state_reg, state_next;
   logic [PHT_IDX_W-1:0]   sweep_addr_reg, sweep_addr_next;
   logic [GHR_W-1:0]       ghr_spec_reg, ghr_spec_next;
   logic [31:0]            mispredict_cnt_reg;

   logic [CTR_W-1:0]       pht_mem [PHT_DEPTH];
   logic                   pht_we;
   logic [PHT_IDX_W-1:0]   pht_waddr;
   logic [CTR_W-1:0]       pht_wdata;
   logic [CTR_W-1:0]       pht_ex_old;

   logic [PHT_IDX_W-1:0]   pc_idx;
   logic [PHT_IDX_W-1:0]   ghr_ext;
   logic [CTR_W-1:0]       pred_ctr;
   logic                   ex_update;
   logic                   btb_we;
   logic                   unused_in_bits;

   // ---------------------------------------------------------------
   // Index generation
   // ---------------------------------------------------------------
   assign pc_idx = PC_F[PHT_IDX_W+1:2];

   // Zero-extend the history up to the PHT index width.
   for (genvar gi = 0; gi < PHT_IDX_W; gi++) begin : g_ghr_ext
      if (gi < GHR_W) begin : g_hist
         assign ghr_ext[gi] = ghr_spec_reg[gi];
      end else begin : g_zero
         assign ghr_ext[gi] = 1'b0;
      end
   end

   if (MODE == MODE_GSHARE) begin : g_gshare
      assign pred_index_F = pc_idx ^ ghr_ext;
   end else begin : g_bimodal
      assign pred_index_F = pc_idx;
   end

   // Bits of the PCs and history outside the used fields are don't-care.
   assign unused_in_bits = ^{PC_F, PC_EX, ghr_EX, ghr_ext};

   // ---------------------------------------------------------------
   // Fetch-side prediction
   // ---------------------------------------------------------------
   assign pred_ctr     = pht_mem[pred_index_F];
   assign ghr_ckpt_F   = ghr_spec_reg;
   assign pred_taken_F = lookup_en_F & btb_hit_F & pred_ctr[CTR_W-1] & ~init_busy;

   assign ex_update = update_en_EX & ~init_busy;
   assign btb_we    = ex_update & taken_EX;

   bp_btb #(
      .BTB_IDX_W (BTB_IDX_W),
      .TAG_W     (TAG_W)
   ) u_btb (
      .clk       (clk),
      .rst       (rst),
      .lookup_pc (PC_F),
      .hit       (btb_hit_F),
      .target    (pred_target_F),
      .wr_en     (btb_we),
      .wr_pc     (PC_EX),
      .wr_target (target_EX)
   );

   // ---------------------------------------------------------------
   // Initialisation FSM
   // ---------------------------------------------------------------

   // State and sweep address registers; reset restarts the sweep.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= INIT;
         sweep_addr_reg <= '0;
      end else begin
         state_reg      <= state_next;
         sweep_addr_reg <= sweep_addr_next;
      end
   end

   // INIT walks every PHT entry once, then RUN holds forever.
   always_comb begin
      state_next      = state_reg;
      sweep_addr_next = sweep_addr_reg;
      init_busy       = 1'b0;
      case (state_reg)
         INIT: begin
            init_busy       = 1'b1;
            sweep_addr_next = sweep_addr_reg + PHT_IDX_W'(1);
            if (sweep_addr_reg == {PHT_IDX_W{1'b1}}) begin
               state_next = RUN;
            end
         end
         RUN: begin
            state_next = RUN;
         end
         default: begin
            state_next = INIT;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Pattern history table
   // ---------------------------------------------------------------

   // One write port shared by the init sweep and EX-stage training.
   always_comb begin
      pht_ex_old = pht_mem[index_EX];
      pht_we     = 1'b0;
      pht_waddr  = sweep_addr_reg;
      pht_wdata  = CTR_WNT;
      if (init_busy) begin
         pht_we = 1'b1;
      end else if (update_en_EX) begin
         pht_we    = 1'b1;
         pht_waddr = index_EX;
         pht_wdata = taken_EX ? CTR_W'(sat_inc(CTR_MAX_W'(pht_ex_old), CTR_W))
                              : CTR_W'(sat_dec(CTR_MAX_W'(pht_ex_old), CTR_W));
      end
   end

   // Counter storage; reads see the old value in the write cycle.
   always_ff @(posedge clk) begin
      if (pht_we) begin
         pht_mem[pht_waddr] <= pht_wdata;
      end
   end

   // ---------------------------------------------------------------
   // Speculative global history
   // ---------------------------------------------------------------

   // EX repair takes priority over the fetch-side speculative shift.
   always_comb begin
      ghr_spec_next = ghr_spec_reg;
      if (!init_busy) begin
         if (update_en_EX && mispredict_EX) begin
            ghr_spec_next = GHR_W'({ghr_EX, taken_EX});
         end else if (lookup_en_F && !stall_F && !mispredict_EX) begin
            ghr_spec_next = GHR_W'({ghr_spec_reg, pred_taken_F});
         end
      end
   end

   // History register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr_spec_reg <= '0;
      end else begin
         ghr_spec_reg <= ghr_spec_next;
      end
   end

   // ---------------------------------------------------------------
   // Mispredict statistics
   // ---------------------------------------------------------------

   // Free-running event counter, wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mispredict_cnt_reg <= '0;
      end else if (ex_update && mispredict_EX) begin
         mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
      end
   end

   assign mispredict_cnt = mispredict_cnt_reg;

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Scoreboard bench for branch_predictor_unit: stimulus pushes expected
// observations, a negedge monitor pops and compares them.
module tb_branch_predictor_unit;

   localparam int PHT_IDX_W = 10;
   localparam int GHR_W     = 10;

   logic                 clk;
   logic                 rst;
   logic                 lookup_en_F;
   logic [31:0]          PC_F;
   logic                 stall_F;
   logic                 pred_taken_F;
   logic [31:0]          pred_target_F;
   logic                 btb_hit_F;
   logic [PHT_IDX_W-1:0] pred_index_F;
   logic [GHR_W-1:0]     ghr_ckpt_F;
   logic                 update_en_EX;
   logic [31:0]          PC_EX;
   logic [PHT_IDX_W-1:0] index_EX;
   logic [GHR_W-1:0]     ghr_EX;
   logic                 taken_EX;
   logic [31:0]          target_EX;
   logic                 mispredict_EX;
   logic                 init_busy;
   logic [31:0]          mispredict_cnt;

   branch_predictor_unit #(
      .PHT_IDX_W (PHT_IDX_W),
      .GHR_W     (GHR_W),
      .BTB_IDX_W (6),
      .TAG_W     (8),
      .CTR_W     (2),
      .MODE      (1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .lookup_en_F    (lookup_en_F),
      .PC_F           (PC_F),
      .stall_F        (stall_F),
      .pred_taken_F   (pred_taken_F),
      .pred_target_F  (pred_target_F),
      .btb_hit_F      (btb_hit_F),
      .pred_index_F   (pred_index_F),
      .ghr_ckpt_F     (ghr_ckpt_F),
      .update_en_EX   (update_en_EX),
      .PC_EX          (PC_EX),
      .index_EX       (index_EX),
      .ghr_EX         (ghr_EX),
      .taken_EX       (taken_EX),
      .target_EX      (target_EX),
      .mispredict_EX  (mispredict_EX),
      .init_busy      (init_busy),
      .mispredict_cnt (mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observation selectors
   localparam int S_TAKEN  = 0;
   localparam int S_TARGET = 1;
   localparam int S_HIT    = 2;
   localparam int S_INDEX  = 3;
   localparam int S_GHR    = 4;
   localparam int S_BUSY   = 5;
   localparam int S_CNT    = 6;
   localparam int S_PHT    = 7;
   localparam int S_SWEEP  = 8;

   int n_checks = 0;
   int n_fail   = 0;

   string       name_q[$];
   int          sel_q[$];
   int          addr_q[$];
   logic [31:0] exp_q[$];

   task automatic expect_val(input string nm, input int sel, input int addr,
                             input logic [31:0] exp);
      name_q.push_back(nm);
      sel_q.push_back(sel);
      addr_q.push_back(addr);
      exp_q.push_back(exp);
   endtask

   function automatic logic [31:0] observe(input int sel, input int addr);
      case (sel)
         S_TAKEN:  return {31'd0, pred_taken_F};
         S_TARGET: return pred_target_F;
         S_HIT:    return {31'd0, btb_hit_F};
         S_INDEX:  return 32'(pred_index_F);
         S_GHR:    return 32'(ghr_ckpt_F);
         S_BUSY:   return {31'd0, init_busy};
         S_CNT:    return mispredict_cnt;
         S_PHT:    return 32'(dut.pht_mem[addr]);
         S_SWEEP:  return 32'(dut.sweep_addr_reg);
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Monitor: compare every queued expectation at the falling edge.
   always @(negedge clk) begin
      while (sel_q.size() > 0) begin
         string       nm;
         int          sel;
         int          addr;
         logic [31:0] exp;
         logic [31:0] act;
         nm   = name_q.pop_front();
         sel  = sel_q.pop_front();
         addr = addr_q.pop_front();
         exp  = exp_q.pop_front();
         act  = observe(sel, addr);
         n_checks++;
         if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
         end else begin
            $display("check %s: 0x%0h ok", nm, act);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", n_checks);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lookup_en_F   = 1'b0;
      PC_F          = 32'd0;
      stall_F       = 1'b0;
      update_en_EX  = 1'b0;
      PC_EX         = 32'd0;
      index_EX      = '0;
      ghr_EX        = '0;
      taken_EX      = 1'b0;
      target_EX     = 32'd0;
      mispredict_EX = 1'b0;
   endtask

   task automatic drive_update(input logic [31:0] pc, input int idx, input logic tk,
                               input logic [31:0] tgt, input logic mis, input int ghr);
      update_en_EX  = 1'b1;
      PC_EX         = pc;
      index_EX      = PHT_IDX_W'(idx);
      taken_EX      = tk;
      target_EX     = tgt;
      mispredict_EX = mis;
      ghr_EX        = GHR_W'(ghr);
   endtask

   task automatic drive_lookup(input logic [31:0] pc, input logic stall);
      lookup_en_F = 1'b1;
      PC_F        = pc;
      stall_F     = stall;
   endtask

   // Run the sweep after a reset release, checking the busy window edges.
   task automatic sweep_check(input string tag);
      for (int k = 1; k <= 1025; k++) begin
         tick();
         if (k == 1 || k == 512 || k == 1023)
            expect_val({tag, "_busy_during"}, S_BUSY, 0, 32'd1);
         if (k == 1024 || k == 1025)
            expect_val({tag, "_busy_done"}, S_BUSY, 0, 32'd0);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      drive_lookup(32'h100, 1'b0);

      // Reset state
      tick();
      tick();
      expect_val("rst_busy", S_BUSY, 0, 32'd1);
      expect_val("rst_taken", S_TAKEN, 0, 32'd0);
      expect_val("rst_hit", S_HIT, 0, 32'd0);
      expect_val("rst_cnt", S_CNT, 0, 32'd0);
      expect_val("rst_ghr", S_GHR, 0, 32'd0);
      tick();
      idle_inputs();
      rst = 1'b1;

      // Initialisation sweep: 1024 busy cycles, entries weakly not-taken
      sweep_check("init");
      expect_val("pht0_init", S_PHT, 0, 32'd1);
      expect_val("pht511_init", S_PHT, 511, 32'd1);
      expect_val("pht1023_init", S_PHT, 1023, 32'd1);

      // Cold BTB lookup
      tick();
      drive_lookup(32'h100, 1'b1);
      expect_val("cold_hit", S_HIT, 0, 32'd0);
      expect_val("cold_target", S_TARGET, 0, 32'd0);
      expect_val("cold_taken", S_TAKEN, 0, 32'd0);

      // Four taken updates, counter saturates at 3
      for (int i = 0; i < 4; i++) begin
         tick();
         idle_inputs();
         drive_update(32'h100, 'h40, 1'b1, 32'h80, 1'b0, 0);
         if (i > 0) expect_val("ctr_train", S_PHT, 'h40, (i == 1) ? 32'd2 : 32'd3);
      end
      tick();
      drive_update(32'h104, 'h40, 1'b1, 32'h200, 1'b0, 0);
      expect_val("ctr_sat4", S_PHT, 'h40, 32'd3);
      tick();
      idle_inputs();
      expect_val("ctr_sat5", S_PHT, 'h40, 32'd3);
      drive_lookup(32'h100, 1'b1);
      expect_val("hot_hit", S_HIT, 0, 32'd1);
      expect_val("hot_taken", S_TAKEN, 0, 32'd1);
      expect_val("hot_target", S_TARGET, 0, 32'h80);
      expect_val("hot_index", S_INDEX, 0, 32'h40);

      // Speculative history: taken, taken, not-taken
      tick();
      drive_lookup(32'h100, 1'b0);
      expect_val("ghr_l1_taken", S_TAKEN, 0, 32'd1);
      expect_val("ghr_l1_ckpt", S_GHR, 0, 32'd0);
      tick();
      drive_lookup(32'h104, 1'b0);
      expect_val("ghr_l2_taken", S_TAKEN, 0, 32'd1);
      expect_val("ghr_l2_ckpt", S_GHR, 0, 32'd1);
      expect_val("ghr_l2_index", S_INDEX, 0, 32'h40);
      expect_val("ghr_l2_target", S_TARGET, 0, 32'h200);
      tick();
      drive_lookup(32'h100, 1'b0);
      expect_val("ghr_l3_taken", S_TAKEN, 0, 32'd0);
      expect_val("ghr_l3_ckpt", S_GHR, 0, 32'd3);
      expect_val("ghr_l3_index", S_INDEX, 0, 32'h43);

      // Repair overrides a same-cycle fetch shift
      tick();
      drive_lookup(32'h100, 1'b0);
      drive_update(32'h300, 'h300, 1'b0, 32'h999, 1'b1, 1);
      expect_val("repair_before", S_GHR, 0, 32'h6);
      expect_val("cnt_before", S_CNT, 0, 32'd0);
      tick();
      idle_inputs();
      drive_lookup(32'h300, 1'b1);
      expect_val("repair_after", S_GHR, 0, 32'h2);
      expect_val("cnt_after", S_CNT, 0, 32'd1);
      expect_val("ctr_dec", S_PHT, 'h300, 32'd0);
      expect_val("btb_nt_nowrite", S_HIT, 0, 32'd0);
      tick();
      drive_lookup(32'h100, 1'b1);
      drive_update(32'h300, 'h300, 1'b0, 32'h999, 1'b0, 0);
      expect_val("btb_kept_hit", S_HIT, 0, 32'd1);
      expect_val("btb_kept_target", S_TARGET, 0, 32'h80);
      tick();
      idle_inputs();
      expect_val("ctr_floor", S_PHT, 'h300, 32'd0);

      // Same-cycle read and write of one entry returns the old counter
      tick();
      drive_lookup(32'h100, 1'b1);
      drive_update(32'h100, 'h42, 1'b1, 32'h80, 1'b0, 0);
      expect_val("raw_index", S_INDEX, 0, 32'h42);
      expect_val("raw_old", S_TAKEN, 0, 32'd0);
      tick();
      idle_inputs();
      drive_lookup(32'h100, 1'b1);
      expect_val("raw_new", S_TAKEN, 0, 32'd1);

      // Reset from RUN clears history, BTB and counter
      tick();
      rst = 1'b0;
      expect_val("rst2_busy", S_BUSY, 0, 32'd1);
      expect_val("rst2_cnt", S_CNT, 0, 32'd0);
      expect_val("rst2_hit", S_HIT, 0, 32'd0);
      expect_val("rst2_taken", S_TAKEN, 0, 32'd0);
      expect_val("rst2_ghr", S_GHR, 0, 32'd0);
      tick();
      idle_inputs();
      rst = 1'b1;
      for (int k = 1; k <= 300; k++) tick();
      expect_val("mid_sweep_addr", S_SWEEP, 0, 32'd300);
      @(negedge clk);
      #1;
      rst = 1'b0;
      expect_val("mid_rst_sweep", S_SWEEP, 0, 32'd0);
      expect_val("mid_rst_busy", S_BUSY, 0, 32'd1);
      expect_val("mid_rst_cnt", S_CNT, 0, 32'd0);
      tick();
      rst = 1'b1;
      sweep_check("restart");

      // Counter wrap at 2^32
      tick();
      force dut.mispredict_cnt_reg = 32'hFFFF_FFFF;
      #1;
      release dut.mispredict_cnt_reg;
      drive_update(32'h500, 'h10, 1'b0, 32'h0, 1'b1, 0);
      expect_val("cnt_preload", S_CNT, 0, 32'hFFFF_FFFF);
      tick();
      idle_inputs();
      expect_val("cnt_wrap", S_CNT, 0, 32'd0);

      @(negedge clk);
      #1;
      if (sel_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", sel_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
